mem_access_unit: RTL and testbench

//  Initiator side of the Y86-64 data-memory interface: accepts one 64-bit load/store per

---
 rtl/mem_pkg.sv | 17 +
 rtl/le_byte_packer.sv | 30 +++
 rtl/mem_access_unit.sv | 107 ++++++++++
 tb/tb_mem_access_unit.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the Y86-64 data-memory access unit.
package mem_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RD_TAIL,
        WR,
        RESP
    } memState_e;

    localparam logic [1:0] STAT_AOK = 2'd1;
    localparam logic [1:0] STAT_ADR = 2'd3;

    localparam int MEM_BYTES_DFLT = 1024;

endpackage

// File: rtl/le_byte_packer.sv
// 64-bit little-endian word register: whole-word load, byte-indexed capture
// for read assembly, and byte-indexed select for write slicing.
module le_byte_packer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        loadEn,
    input  logic [63:0] loadWord,
    input  logic        capEn,
    input  logic [2:0]  capIdx,
    input  logic [7:0]  capByte,
    input  logic [2:0]  selIdx,
    output logic [63:0] word,
    output logic [7:0]  selByte
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word <= '0;
        end else if (loadEn) begin
            word <= loadWord;
        end else if (capEn) begin
            word[{capIdx, 3'b000} +: 8] <= capByte;
        end
    end

    assign selByte = word[{selIdx, 3'b000} +: 8];

endmodule

// File: rtl/mem_access_unit.sv
// Y86-64 data-memory initiator: one 64-bit load/store per request, performed
// as eight byte accesses on a byte-wide synchronous RAM port.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int MEM_BYTES = MEM_BYTES_DFLT,
    parameter int RD_LAT    = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic        reqWrite,
    input  logic [63:0] reqAddr,
    input  logic [63:0] reqData,
    output logic        rspValid,
    input  logic        rspReady,
    output logic [63:0] valM,
    output logic [1:0]  rspStat,
    output logic [63:0] memAddr,
    output logic        memRead,
    output logic        memWrite,
    output logic [7:0]  memWData,
    input  logic [7:0]  memRData
);

    if (RD_LAT != 1) begin : gBadRdLat
        $error("mem_access_unit: only RD_LAT == 1 is supported");
    end

    localparam logic [63:0] LAST_LEGAL = 64'(MEM_BYTES - 8);

    memState_e   state, stateNext;
    logic [2:0]  cnt;
    logic [63:0] addr;
    logic        isWrite;
    logic        accept;
    logic        addrLegal;
    logic        capEn;
    logic [2:0]  capIdx;
    logic [63:0] word;
    logic [7:0]  selByte;

    // Unsigned 64-bit compare done up front, so addr+cnt can never wrap later.
    assign addrLegal = (reqAddr <= LAST_LEGAL);
    assign accept    = reqValid && (state == IDLE);

    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE:    if (reqValid) stateNext = !addrLegal ? RESP : (reqWrite ? WR : RD);
            RD:      if (cnt == 3'd7) stateNext = RD_TAIL;
            RD_TAIL: stateNext = RESP;
            WR:      if (cnt == 3'd7) stateNext = RESP;
            RESP:    if (rspReady) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            addr    <= '0;
            isWrite <= 1'b0;
            rspStat <= STAT_AOK;
        end else begin
            state <= stateNext;
            if (accept) begin
                addr    <= reqAddr;
                isWrite <= reqWrite;
                rspStat <= addrLegal ? STAT_AOK : STAT_ADR;
                cnt     <= '0;
            end else if (state == RD || state == WR) begin
                cnt <= cnt + 3'd1;
            end
        end
    end

    // Read data trails its strobe by one cycle, hence the cnt-1 capture index.
    assign capEn  = (state == RD && cnt != 3'd0) || (state == RD_TAIL);
    assign capIdx = (state == RD_TAIL) ? 3'd7 : cnt - 3'd1;

    le_byte_packer uPacker (
        .clk      (clk),
        .rst_n    (rst_n),
        .loadEn   (accept),
        .loadWord ((reqWrite && addrLegal) ? reqData : 64'd0),
        .capEn    (capEn),
        .capIdx   (capIdx),
        .capByte  (memRData),
        .selIdx   (cnt),
        .word     (word),
        .selByte  (selByte)
    );

    assign reqReady = (state == IDLE);
    assign rspValid = (state == RESP);
    assign memRead  = (state == RD);
    assign memWrite = (state == WR);
    assign memAddr  = (memRead || memWrite) ? addr + 64'(cnt) : 64'd0;
    assign memWData = memWrite ? selByte : 8'd0;
    assign valM     = (rspValid && !isWrite && rspStat == STAT_AOK) ? word : 64'd0;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized scoreboard bench for mem_access_unit with a byte RAM model and a
// byte-array reference memory.
module tb_mem_access_unit;
    import mem_pkg::*;

    localparam int MEMSZ = 1024;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        reqValid = 1'b0;
    logic        reqReady;
    logic        reqWrite = 1'b0;
    logic [63:0] reqAddr = '0;
    logic [63:0] reqData = '0;
    logic        rspValid;
    logic        rspReady = 1'b0;
    logic [63:0] valM;
    logic [1:0]  rspStat;
    logic [63:0] memAddr;
    logic        memRead;
    logic        memWrite;
    logic [7:0]  memWData;
    logic [7:0]  memRData = '0;

    mem_access_unit #(.MEM_BYTES(MEMSZ), .RD_LAT(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
        .reqAddr(reqAddr), .reqData(reqData),
        .rspValid(rspValid), .rspReady(rspReady), .valM(valM), .rspStat(rspStat),
        .memAddr(memAddr), .memRead(memRead), .memWrite(memWrite),
        .memWData(memWData), .memRData(memRData)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] val;
        logic [1:0]  stat;
        int          acceptCyc;
        int          lat;
        int          nStrobes;
    } expT;

    logic [7:0]  ram    [0:MEMSZ-1];
    logic [7:0]  refMem [0:MEMSZ-1];
    expT         expQ[$];
    int          cyc = 0;
    int          nChecks = 0;
    int          nPass = 0;
    int          lastHs = -100;
    int          holdLow = 0;
    logic [63:0] curAddr = '0;
    logic [63:0] curData = '0;
    logic        curWrite = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Byte RAM: write on edge, registered one-cycle read.
    always @(posedge clk) begin
        if (memWrite && memAddr < 64'(MEMSZ)) ram[memAddr[9:0]] <= memWData;
        if (memRead) memRData <= ram[memAddr[9:0]];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [63:0] refLoad(input logic [63:0] a);
        logic [63:0] v = '0;
        for (int i = 0; i < 8; i++) v[8*i +: 8] = refMem[int'(a[9:0]) + i];
        return v;
    endfunction

    // Consumer: random backpressure, forced low for holdLow response cycles.
    initial forever begin
        @(posedge clk);
        #1;
        if (rspValid && holdLow > 0) begin
            rspReady = 1'b0;
            holdLow--;
        end else begin
            rspReady = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: bus strobes against the current transaction, responses against the queue.
    initial begin
        int busIdx = 0;
        bit seen = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                busIdx = 0;
                seen = 0;
            end else begin
                if (memRead || memWrite) begin
                    check("strobe_exclusive", 64'(memRead & memWrite), 0);
                    check("strobe_type", 64'(memWrite), 64'(curWrite));
                    check("strobe_addr", memAddr, curAddr + 64'(busIdx));
                    if (memWrite) check("write_byte", memWData, curData[8*(busIdx % 8) +: 8]);
                    busIdx++;
                end
                if (rspValid) begin
                    if (expQ.size() == 0) begin
                        check("unexpected_rsp", 1, 0);
                    end else begin
                        if (!seen) begin
                            seen = 1;
                            check("rsp_latency", 64'(cyc - expQ[0].acceptCyc), 64'(expQ[0].lat));
                        end
                        check("valM", valM, expQ[0].val);
                        check("rspStat", 64'(rspStat), 64'(expQ[0].stat));
                        check("reqReady_busy", 64'(reqReady), 0);
                        if (rspReady) begin
                            check("strobe_count", 64'(busIdx), 64'(expQ[0].nStrobes));
                            lastHs = cyc;
                            void'(expQ.pop_front());
                            seen = 0;
                        end
                    end
                end else if (reqReady) begin
                    busIdx = 0;
                end
            end
        end
    end

    task automatic doReq(input logic w, input logic [63:0] a, input logic [63:0] d);
        expT e;
        int n = 0;
        bit legal;
        @(negedge clk);
        reqValid = 1'b1; reqWrite = w; reqAddr = a; reqData = d;
        while (!reqReady && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!reqReady) begin
            check("accept_timeout", 0, 1);
            reqValid = 1'b0;
            return;
        end
        if (n > 0) check("accept_after_hs", 64'(cyc), 64'(lastHs + 1));
        legal = (a <= 64'(MEMSZ - 8));
        curAddr = a; curData = d; curWrite = w;
        e.acceptCyc = cyc;
        if (!legal) begin
            e.val = 0; e.stat = STAT_ADR; e.lat = 1; e.nStrobes = 0;
        end else if (w) begin
            for (int i = 0; i < 8; i++) refMem[int'(a[9:0]) + i] = d[8*i +: 8];
            e.val = 0; e.stat = STAT_AOK; e.lat = 9; e.nStrobes = 8;
        end else begin
            e.val = refLoad(a); e.stat = STAT_AOK; e.lat = 10; e.nStrobes = 8;
        end
        expQ.push_back(e);
        @(posedge clk);
        #1;
        reqValid = 1'b0;
        reqAddr = {$urandom, $urandom};
        reqData = {$urandom, $urandom};
        reqWrite = 1'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while ((expQ.size() != 0 || !reqReady) && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 64'(n < 500), 1);
    endtask

    initial begin
        logic [63:0] a, d, rstAddr, rstData;
        for (int i = 0; i < MEMSZ; i++) begin
            ram[i] = 8'($urandom);
            refMem[i] = ram[i];
        end

        #12;
        check("rst_reqReady", 64'(reqReady), 1);
        check("rst_rspValid", 64'(rspValid), 0);
        check("rst_valM", valM, 0);
        check("rst_rspStat", 64'(rspStat), 64'(STAT_AOK));
        check("rst_strobes", 64'({memRead, memWrite}), 0);
        check("rst_memAddr", memAddr, 0);
        check("rst_memWData", 64'(memWData), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed: store/load, boundaries, unaligned overlap.
        doReq(1'b1, 64'h10, 64'h0807060504030201);
        doReq(1'b0, 64'h10, 64'h0);
        doReq(1'b0, 64'h3F8, 64'h0);
        doReq(1'b0, 64'h3F9, 64'h0);
        doReq(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1234);
        doReq(1'b1, 64'h13, 64'hAABBCCDDEEFF0011);
        doReq(1'b0, 64'h10, 64'h0);

        // Stalled response with a request already waiting behind it.
        drain();
        holdLow = 5;
        doReq(1'b0, 64'h13, 64'h0);
        doReq(1'b0, 64'h100, 64'h0);

        for (int k = 0; k < 30; k++) begin
            int r = $urandom_range(0, 9);
            if (r == 0)      a = {$urandom, $urandom};
            else if (r == 1) a = 64'(MEMSZ - 7 + $urandom_range(0, 6));
            else             a = 64'($urandom_range(0, MEMSZ - 8));
            d = {$urandom, $urandom};
            doReq(1'($urandom), a, d);
        end
        drain();

        // Reset during the fourth write cycle: bytes 0-2 land, the rest stay.
        rstAddr = 64'h200;
        rstData = 64'h1122334455667788;
        @(negedge clk);
        reqValid = 1'b1; reqWrite = 1'b1; reqAddr = rstAddr; reqData = rstData;
        curAddr = rstAddr; curData = rstData; curWrite = 1'b1;
        @(posedge clk);
        #1;
        reqValid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_memWrite", 64'(memWrite), 0);
        check("abort_memRead", 64'(memRead), 0);
        check("abort_idle", 64'(reqReady), 1);
        check("abort_rspValid", 64'(rspValid), 0);
        for (int i = 0; i < 3; i++) refMem[int'(rstAddr[9:0]) + i] = rstData[8*i +: 8];
        @(negedge clk);
        rst_n = 1'b1;
        doReq(1'b0, rstAddr, 64'h0);
        drain();

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
